// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU, video and RAM signal bundle around the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_address;
    logic [7:0]        cpu_out;
    logic              cpu_we;
    logic [7:0]        cpu_in;
    logic              cpu_chipen;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_address;
    logic              vid_ack;
    logic [7:0]        vid_data;
    logic [ADDR_W-1:0] ram_address;
    logic [7:0]        ram_out;
    logic              ram_we;
    logic [7:0]        ram_in;

    modport slave (
        input  cpu_req, cpu_address, cpu_out, cpu_we, vid_req, vid_address, ram_in,
        output cpu_in, cpu_chipen, vid_ack, vid_data, ram_address, ram_out, ram_we
    );

    modport master (
        output cpu_req, cpu_address, cpu_out, cpu_we, vid_req, vid_address, ram_in,
        input  cpu_in, cpu_chipen, vid_ack, vid_data, ram_address, ram_out, ram_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-cycle-slot arbiter sharing one sync RAM between CPU and video
// Video has priority; a saturating burst counter guarantees the CPU a slot.
module mem_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int VID_BURST = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int RUN_W = $clog2(VID_BURST + 1);

    typedef enum logic [2:0] {IDLE, CPU_A, CPU_B, VID_A, VID_B} state_t;

    state_t            state;
    logic [RUN_W-1:0]  vid_run;
    logic [RUN_W-1:0]  vid_run_inc;
    logic [ADDR_W-1:0] addr_q;
    logic              burst_done;
    logic              cpu_go;

    always_comb begin
        burst_done  = (vid_run >= RUN_W'(VID_BURST));
        cpu_go      = bus.cpu_req && (burst_done || !bus.vid_req);
        vid_run_inc = burst_done ? vid_run : vid_run + 1'b1;
    end

    // Outside the A states the RAM sees the previous address so its output stays put.
    always_comb begin
        bus.ram_address = addr_q;
        bus.ram_we      = 1'b0;
        case (state)
            CPU_A: begin
                bus.ram_address = bus.cpu_address;
                bus.ram_we      = bus.cpu_we;
            end
            VID_A:   bus.ram_address = bus.vid_address;
            default: ;
        endcase
    end

    assign bus.ram_out  = bus.cpu_out;
    assign bus.vid_ack  = (state == VID_B);
    assign bus.vid_data = bus.ram_in;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            vid_run        <= '0;
            addr_q         <= '0;
            bus.cpu_in     <= 8'h00;
            bus.cpu_chipen <= 1'b0;
        end else begin
            addr_q         <= bus.ram_address;
            bus.cpu_chipen <= (state == CPU_B);
            if (state == CPU_B) begin
                bus.cpu_in <= bus.ram_in;
            end
            case (state)
                IDLE, VID_B: begin
                    if (cpu_go) begin
                        state   <= CPU_A;
                        vid_run <= '0;
                    end else if (bus.vid_req) begin
                        state   <= VID_A;
                        vid_run <= vid_run_inc;
                    end else begin
                        state   <= IDLE;
                        vid_run <= '0;
                    end
                end
                // The CPU address is stale during its chipen cycle, so it cannot win here.
                CPU_B: begin
                    if (bus.vid_req) begin
                        state   <= VID_A;
                        vid_run <= vid_run_inc;
                    end else begin
                        state   <= IDLE;
                        vid_run <= '0;
                    end
                end
                CPU_A:   state <= CPU_B;
                VID_A:   state <= VID_B;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
